// File: rtl/fpga_conf_pkg.sv
// Shared command codes, frame length and major-mode encodings for the HF config register block.
package fpga_conf_pkg;

    localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
    localparam logic [3:0] CMD_WRITE       = 4'b0010;
    localparam logic [3:0] CMD_READ        = 4'b0011;

    localparam int unsigned FRAME_BITS = 16;

    typedef enum logic [2:0] {
        HF_READ_TX       = 3'b000,
        HF_READ_RX_XCORR = 3'b001,
        HF_SIMULATOR     = 3'b010,
        HF_ISO14443A     = 3'b011,
        HF_SNOOP         = 3'b100,
        MODE_OFF         = 3'b111
    } major_mode_e;

endpackage

// File: rtl/spi_sync_rx.sv
// Oversampling SPI slave: synchronises spck/ncs/mosi into the local clock, assembles 16-bit
// frames and shifts readback data out on miso.
module spi_sync_rx
    import fpga_conf_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spck,
    input  logic        ncs,
    input  logic        mosi,
    input  logic [7:0]  tx_data,
    output logic        miso,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_word
);

    logic [SYNC_STAGES-1:0] spck_sync_q, ncs_sync_q, mosi_sync_q;
    logic                   spck_prev_q, ncs_prev_q;
    logic                   active_q;
    logic [4:0]             bit_cnt_q;
    logic [15:0]            shift_rx_q, shift_tx_q;
    logic                   spck_s, ncs_s, mosi_s;
    logic                   spck_rise, spck_fall, ncs_rise, ncs_fall;

    assign spck_s = spck_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign spck_rise = spck_s & ~spck_prev_q;
    assign spck_fall = ~spck_s & spck_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;

    // Syncs reset low so a chip select already asserted at reset release never opens a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            spck_sync_q <= '0;
            ncs_sync_q  <= '0;
            mosi_sync_q <= '0;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
            active_q    <= 1'b0;
            bit_cnt_q   <= '0;
            shift_rx_q  <= '0;
            shift_tx_q  <= '0;
            miso        <= 1'b0;
        end else begin
            spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], spck};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            spck_prev_q <= spck_s;
            ncs_prev_q  <= ncs_s;
            if (ncs_fall) begin
                active_q   <= 1'b1;
                bit_cnt_q  <= '0;
                shift_tx_q <= {tx_data, 8'h00};
            end else if (ncs_rise) begin
                active_q <= 1'b0;
            end else if (active_q) begin
                if (spck_rise) begin
                    shift_rx_q <= {shift_rx_q[14:0], mosi_s};
                    if (bit_cnt_q != 5'd31) begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                if (spck_fall) begin
                    miso       <= shift_tx_q[15];
                    shift_tx_q <= {shift_tx_q[14:0], 1'b0};
                end
            end
        end
    end

    assign frame_done = ncs_rise & active_q;
    assign frame_ok   = (bit_cnt_q == 5'(FRAME_BITS));
    assign frame_word = shift_rx_q;

endmodule

// File: rtl/fpga_conf_regs.sv
// SPI-programmed config register file with readback, frame error flag and a guard window that
// parks major_mode at MODE_OFF whenever the mode bits of reg0 change.
module fpga_conf_regs
    import fpga_conf_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 4,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                  ck_1356meg,
    input  logic                  rst,
    input  logic                  spck,
    input  logic                  ncs,
    input  logic                  mosi,
    output logic                  miso,
    output logic [7:0]            conf_word,
    output logic [2:0]            major_mode,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [3:0]            wr_addr,
    output logic                  mode_guard,
    output logic                  frame_err,
    input  logic                  err_clr
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TW = $clog2(GUARD_CYCLES + 1);
    localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);

    logic [7:0]    regs_q [NUM_REGS];
    logic [AW-1:0] read_ptr_q;
    logic [TW-1:0] timer_q;

    logic        frame_done, frame_ok;
    logic [15:0] frame_word;
    logic [3:0]  cmd, addr, wr_idx;
    logic [7:0]  data;
    logic        addr_ok, wr_en, ptr_en, err_set, mode_change;

    spi_sync_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk       (ck_1356meg),
        .rst       (rst),
        .spck      (spck),
        .ncs       (ncs),
        .mosi      (mosi),
        .tx_data   (regs_q[read_ptr_q]),
        .miso      (miso),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .frame_word(frame_word)
    );

    assign cmd     = frame_word[15:12];
    assign addr    = frame_word[11:8];
    assign data    = frame_word[7:0];
    assign addr_ok = ({28'd0, addr} < NUM_REGS);

    always_comb begin
        wr_en   = 1'b0;
        ptr_en  = 1'b0;
        err_set = 1'b0;
        wr_idx  = addr;
        if (frame_done) begin
            if (!frame_ok) begin
                err_set = 1'b1;
            end else begin
                case (cmd)
                    CMD_SET_CONFREG: begin
                        wr_en  = 1'b1;
                        wr_idx = 4'd0;
                    end
                    CMD_WRITE: begin
                        wr_en   = addr_ok;
                        err_set = ~addr_ok;
                    end
                    CMD_READ: begin
                        ptr_en  = addr_ok;
                        err_set = ~addr_ok;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mode_change = wr_en && (wr_idx == 4'd0) && (data[7:5] != regs_q[0][7:5]);

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            read_ptr_q <= '0;
            timer_q    <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            mode_guard <= 1'b0;
            major_mode <= 3'b000;
            frame_err  <= 1'b0;
        end else begin
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs_q[wr_idx[AW-1:0]] <= data;
                wr_addr                <= wr_idx;
            end
            if (ptr_en) begin
                read_ptr_q <= addr[AW-1:0];
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            // A new mode change reloads the timer even if a guard is already running.
            if (mode_change) begin
                mode_guard <= 1'b1;
                timer_q    <= GUARD_LOAD;
                major_mode <= MODE_OFF;
            end else if (mode_guard) begin
                if (timer_q == '0) begin
                    mode_guard <= 1'b0;
                    major_mode <= regs_q[0][7:5];
                end else begin
                    timer_q <= timer_q - TW'(1);
                end
            end
        end
    end

    assign conf_word = regs_q[0];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
    end

endmodule

// File: tb/tb_fpga_conf_regs.sv
// Self-checking bench: table-driven SPI frames plus hand sequences for guard and reset corners.
module tb_fpga_conf_regs;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned GUARD    = 300;
    localparam int unsigned HALF     = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spck = 1'b0, ncs = 1'b1, mosi = 1'b0, err_clr = 1'b0;
    logic        miso;
    logic [7:0]  conf_word;
    logic [2:0]  major_mode;
    logic [31:0] regs_flat;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic        mode_guard, frame_err;

    int total = 0;
    int bad   = 0;

    fpga_conf_regs #(
        .NUM_REGS    (NUM_REGS),
        .GUARD_CYCLES(GUARD),
        .SYNC_STAGES (2)
    ) dut (
        .ck_1356meg(clk),
        .rst       (rst),
        .spck      (spck),
        .ncs       (ncs),
        .mosi      (mosi),
        .miso      (miso),
        .conf_word (conf_word),
        .major_mode(major_mode),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .mode_guard(mode_guard),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        bit          wr;
        logic [3:0]  waddr;
        logic [7:0]  wdata;
        logic [15:0] miso_exp;
        bit          err;
        bit          clr;
        logic [31:0] regs;
    } vec_t;

    wr_t  wr_q[$];
    vec_t vecs[12];

    int   cyc = 0, run = 0, last_run = 0, run_end = 0, s_prev = 0, s_last = 0, guard_rises = 0;
    logic guard_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    // Scoreboard side: every write strobe consumes one expected write.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (wr_strobe) begin
            s_prev = s_last;
            s_last = cyc;
            if (wr_q.size() == 0) begin
                check("unexpected wr_strobe", 32'd1, 32'd0);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
                check("wr_data", {24'd0, regs_flat[8*int'(e.addr) +: 8]}, {24'd0, e.data});
            end
        end
        if (major_mode == 3'b111) begin
            run++;
        end else if (run > 0) begin
            last_run = run;
            run_end  = cyc;
            run      = 0;
        end
        if (mode_guard && !guard_d) guard_rises++;
        guard_d = mode_guard;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        clk_wait(HALF);
        m    = miso;
        spck = 1'b1;
        clk_wait(HALF);
        spck = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, output logic [15:0] rx);
        logic m;
        rx  = '0;
        ncs = 1'b0;
        clk_wait(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(word[nbits-1-i], m);
            if (i > 0) rx = {rx[14:0], m};
        end
        clk_wait(HALF);
        rx  = {rx[14:0], miso};
        ncs = 1'b1;
        clk_wait(10);
    endtask

    initial begin
        logic [15:0] rx;
        logic        m;
        int          g;
        logic [15:0] w6;

        vecs[0]  = '{32'h02255, 16, 1'b1, 4'd2, 8'h55, 16'h4200, 1'b0, 1'b0, 32'h0055_0042};
        vecs[1]  = '{32'h03200, 16, 1'b0, 4'd0, 8'h00, 16'h4200, 1'b0, 1'b0, 32'h0055_0042};
        vecs[2]  = '{32'h00000, 16, 1'b0, 4'd0, 8'h00, 16'h5500, 1'b0, 1'b0, 32'h0055_0042};
        vecs[3]  = '{32'h01077, 15, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b1, 1'b1, 32'h0055_0042};
        vecs[4]  = '{32'h02299, 17, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b1, 1'b1, 32'h0055_0042};
        vecs[5]  = '{32'h02F11, 16, 1'b0, 4'd0, 8'h00, 16'h5500, 1'b1, 1'b1, 32'h0055_0042};
        vecs[6]  = '{32'h02311, 16, 1'b1, 4'd3, 8'h11, 16'h5500, 1'b0, 1'b0, 32'h1155_0042};
        vecs[7]  = '{32'h03500, 16, 1'b0, 4'd0, 8'h00, 16'h5500, 1'b1, 1'b1, 32'h1155_0042};
        vecs[8]  = '{32'h00000, 16, 1'b0, 4'd0, 8'h00, 16'h5500, 1'b0, 1'b0, 32'h1155_0042};
        vecs[9]  = '{32'h03300, 16, 1'b0, 4'd0, 8'h00, 16'h5500, 1'b0, 1'b0, 32'h1155_0042};
        vecs[10] = '{32'h04321, 16, 1'b0, 4'd0, 8'h00, 16'h1100, 1'b0, 1'b0, 32'h1155_0042};
        vecs[11] = '{32'h021A5, 16, 1'b1, 4'd1, 8'hA5, 16'h1100, 1'b0, 1'b0, 32'h1155_A542};

        // Reset state
        clk_wait(4);
        check("rst conf_word", {24'd0, conf_word}, 32'h0);
        check("rst major_mode", {29'd0, major_mode}, 32'h0);
        check("rst regs_flat", regs_flat, 32'h0);
        check("rst miso", {31'd0, miso}, 32'h0);
        check("rst wr_strobe", {31'd0, wr_strobe}, 32'h0);
        check("rst wr_addr", {28'd0, wr_addr}, 32'h0);
        check("rst mode_guard", {31'd0, mode_guard}, 32'h0);
        check("rst frame_err", {31'd0, frame_err}, 32'h0);
        rst = 1'b0;
        clk_wait(4);
        check("post-rst no guard", {31'd0, mode_guard}, 32'h0);

        // SET_CONFREG with a mode change: exactly GUARD cycles of MODE_OFF
        expect_wr(4'd0, 8'h42);
        send_frame(32'h1042, 16, rx);
        check("t1 conf_word", {24'd0, conf_word}, 32'h42);
        check("t1 readback", {16'd0, rx}, 32'h0);
        check("t1 guard active", {29'd0, major_mode}, 32'h7);
        clk_wait(GUARD + 20);
        check("t1 off run length", last_run, GUARD);
        check("t1 off end", run_end - s_last, GUARD);
        check("t1 major_mode", {29'd0, major_mode}, 32'h2);
        check("t1 mode_guard", {31'd0, mode_guard}, 32'h0);

        // Table-driven frames
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) expect_wr(vecs[i].waddr, vecs[i].wdata);
            send_frame(vecs[i].word, vecs[i].nbits, rx);
            if (vecs[i].nbits == 16)
                check($sformatf("v%0d miso", i), {16'd0, rx}, {16'd0, vecs[i].miso_exp});
            check($sformatf("v%0d frame_err", i), {31'd0, frame_err}, {31'd0, vecs[i].err});
            check($sformatf("v%0d regs", i), regs_flat, vecs[i].regs);
            if (vecs[i].clr) begin
                err_clr = 1'b1;
                clk_wait(1);
                err_clr = 1'b0;
                clk_wait(1);
                check($sformatf("v%0d err_clr", i), {31'd0, frame_err}, 32'h0);
            end
        end
        check("table writes drained", wr_q.size(), 0);

        // Mode change during guard restarts it; same-mode write does not guard
        expect_wr(4'd0, 8'h20);
        send_frame(32'h1020, 16, rx);
        expect_wr(4'd0, 8'h80);
        send_frame(32'h1080, 16, rx);
        check("t5 still off", {29'd0, major_mode}, 32'h7);
        clk_wait(GUARD + 20);
        check("t5 off run length", last_run, s_last - s_prev + GUARD);
        check("t5 off end", run_end - s_last, GUARD);
        check("t5 major_mode", {29'd0, major_mode}, 32'h4);
        g = guard_rises;
        expect_wr(4'd0, 8'h90);
        send_frame(32'h1090, 16, rx);
        clk_wait(5);
        check("t5 no new guard", guard_rises, g);
        check("t5 conf_word", {24'd0, conf_word}, 32'h90);
        check("t5 major kept", {29'd0, major_mode}, 32'h4);

        // Reset in the middle of a frame discards it
        w6  = 16'h2377;
        ncs = 1'b0;
        clk_wait(HALF);
        for (int i = 0; i < 8; i++) spi_bit(w6[15-i], m);
        rst = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(2);
        check("t6 regs after rst", regs_flat, 32'h0);
        check("t6 major after rst", {29'd0, major_mode}, 32'h0);
        for (int i = 8; i < 16; i++) spi_bit(w6[15-i], m);
        clk_wait(HALF);
        ncs = 1'b1;
        clk_wait(10);
        check("t6 no decode", regs_flat, 32'h0);
        check("t6 no err", {31'd0, frame_err}, 32'h0);
        expect_wr(4'd3, 8'h77);
        send_frame(32'h2377, 16, rx);
        check("t6 readback ptr reset", {16'd0, rx}, 32'h0);
        check("t6 regs", regs_flat, 32'h7700_0000);
        send_frame(32'h3300, 16, rx);
        send_frame(32'h0000, 16, rx);
        check("t6 readback reg3", {16'd0, rx}, 32'h7700);
        check("t6 frame_err", {31'd0, frame_err}, 32'h0);
        check("all writes drained", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
